// File: rtl/led_strip_pkg.sv
// led_strip_pkg: shared state type, frame constants and end-frame sizing for the SK9822 scheduler
package led_strip_pkg;

    typedef enum logic [1:0] {IDLE, START, LEDS, END} state_t;

    localparam logic [31:0] START_WORD    = 32'h0000_0000;
    localparam logic [31:0] END_WORD      = 32'h0000_0000;
    localparam logic [2:0]  BRIGHT_PREFIX = 3'b111;

    // one end-frame word per 64 LEDs, plus one, clocks the data through the whole chain
    function automatic int n_end_f(input int n);
        return 1 + n / 64;
    endfunction

endpackage

// File: rtl/led_strip_refresh_timer.sv
// led_strip_refresh_timer: free-running frame-rate divider, pulses tick on the cycle it wraps
module led_strip_refresh_timer
    import led_strip_pkg::*;
#(
    parameter int clk_mhz    = 27,
    parameter int refresh_hz = 60
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PERIOD = clk_mhz * 1_000_000 / refresh_hz;
    localparam int TW     = PERIOD > 1 ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

    logic [TW-1:0] count;

    assign tick = count == LAST;

    // count 0..PERIOD-1 and wrap, independent of whatever the scheduler is doing
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else        count <= tick ? '0 : count + 1'b1;

endmodule

// File: rtl/led_strip_scheduler.sv
// led_strip_scheduler: SK9822 frame sequencer (start word, LED words, end words) on a valid/ready word stream.
// Define LED_STRIP_SCHEDULER_SNAPSHOT_EN to latch the whole frame at launch instead of sampling LEDs live.
module led_strip_scheduler
    import led_strip_pkg::*;
#(
    parameter int clk_mhz    = 27,
    parameter int n_leds     = 13,
    parameter int refresh_hz = 60
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:n_leds-1][31:0] data_rgb,
    input  logic                    frame_req,
    input  logic                    word_ready,
    output logic [31:0]             word_data,
    output logic                    word_valid,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int N_END = n_end_f(n_leds);
    localparam int IW    = n_leds > 1 ? $clog2(n_leds) : 1;
    localparam int EW    = N_END > 1 ? $clog2(N_END) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(n_leds - 1);
    localparam logic [EW-1:0] LAST_END = EW'(N_END - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt, led_sel;
    logic [EW-1:0] end_cnt, end_cnt_nxt;
    logic [31:0]   data_nxt, src_word, led_word;
    logic          valid_nxt, done_nxt, pending, tick, xfer, launch;

    led_strip_refresh_timer #(
        .clk_mhz   (clk_mhz),
        .refresh_hz(refresh_hz)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign xfer     = word_valid & word_ready;
    assign launch   = state == IDLE && pending;
    assign busy     = state != IDLE;
    assign led_sel  = (state == LEDS && idx != LAST_IDX) ? idx + 1'b1 : '0;
    assign led_word = src_word | {BRIGHT_PREFIX, 29'b0};

`ifdef LED_STRIP_SCHEDULER_SNAPSHOT_EN
    logic [31:0] snap [n_leds];

    // freeze the entire frame as it launches so one frame never mixes old and new pixels
    always_ff @(posedge clk)
        if (launch)
            for (int i = 0; i < n_leds; i++) snap[i] <= data_rgb[i];

    assign src_word = snap[led_sel];
`else
    assign src_word = data_rgb[led_sel];
`endif

    // frame requests and timer wraps coalesce; a request landing on the launch edge stays pending
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pending <= 1'b0;
        else        pending <= frame_req | tick | (pending & ~launch);

    // sequence the frame and preload the next word on each transfer so the stream never bubbles
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        end_cnt_nxt = end_cnt;
        data_nxt    = word_data;
        valid_nxt   = word_valid;
        done_nxt    = 1'b0;
        case (state)
            IDLE: if (pending) begin
                state_nxt = START;
                data_nxt  = START_WORD;
                valid_nxt = 1'b1;
            end
            START: if (xfer) begin
                state_nxt = LEDS;
                idx_nxt   = '0;
                data_nxt  = led_word;
            end
            LEDS: if (xfer) begin
                if (idx == LAST_IDX) begin
                    state_nxt   = END;
                    end_cnt_nxt = '0;
                    data_nxt    = END_WORD;
                end else begin
                    idx_nxt  = led_sel;
                    data_nxt = led_word;
                end
            end
            END: if (xfer) begin
                if (end_cnt == LAST_END) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    data_nxt  = '0;
                    valid_nxt = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    end_cnt_nxt = end_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state and registered word-stream outputs; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            end_cnt    <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            end_cnt    <= end_cnt_nxt;
            word_data  <= data_nxt;
            word_valid <= valid_nxt;
            frame_done <= done_nxt;
        end

endmodule

// File: tb/tb_led_strip_scheduler.sv
// tb_led_strip_scheduler: directed checks of frame format, stalls, coalescing, reset abort, live/snapshot sampling and refresh timing
module tb_led_strip_scheduler;

    localparam int N = 13;

    logic clk = 1'b0, rst_n = 1'b0, rst_t = 1'b0, frame_req = 1'b0, word_ready = 1'b1, sel = 1'b0;
    logic [0:N-1][31:0] data_rgb;
    logic [31:0] m_data, t_data, word_data;
    logic m_valid, t_valid, m_busy, t_busy, m_done, t_done, word_valid, busy, frame_done;

    int tests = 0, fails = 0;
    logic [31:0] got[$];
    logic [31:0] held, orig;
    int busy_cyc, done_cnt, last_xfer, starts, start2, done1, stall_bad;
    int st[4], dn[4];
    int n_st, n_dn;
    bit prev_t;

    always #5 clk = ~clk;

    led_strip_scheduler dut (
        .clk(clk), .rst_n(rst_n), .data_rgb(data_rgb), .frame_req(frame_req), .word_ready(word_ready),
        .word_data(m_data), .word_valid(m_valid), .busy(m_busy), .frame_done(m_done)
    );

    led_strip_scheduler #(.clk_mhz(1), .n_leds(N), .refresh_hz(1000)) dut_t (
        .clk(clk), .rst_n(rst_t), .data_rgb(data_rgb), .frame_req(frame_req), .word_ready(word_ready),
        .word_data(t_data), .word_valid(t_valid), .busy(t_busy), .frame_done(t_done)
    );

    assign word_data  = sel ? t_data  : m_data;
    assign word_valid = sel ? t_valid : m_valid;
    assign busy       = sel ? t_busy  : m_busy;
    assign frame_done = sel ? t_done  : m_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] led(input int i);
        logic [31:0] w;
        w = data_rgb[i];
        return {3'b111, w[28:0]};
    endfunction

    function automatic logic [31:0] word_at(input int k);
        return k < got.size() ? got[k] : 32'hxxxx_xxxx;
    endfunction

    task automatic check_frame(input string tag, input int base);
        check({tag, "_start"}, word_at(base), 32'h0);
        for (int i = 0; i < N; i++) check($sformatf("%s_led%0d", tag, i), word_at(base + 1 + i), led(i));
        check({tag, "_end"}, word_at(base + N + 1), 32'h0);
    endtask

    // drive frame_req from a cycle mask, optionally stall a word, alter LED 12 mid-frame or reset mid-frame
    task automatic run_frame(input int ncyc, input logic [63:0] reqs, input int stall_pos,
                             input int chg_pos, input logic [31:0] chg_val, input int rst_pos);
        int stalls;
        bit prev;
        stalls = 0; prev = 0;
        got.delete();
        busy_cyc = 0; done_cnt = 0; last_xfer = -1; starts = 0; start2 = -1; done1 = -1; stall_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            frame_req = (c < 64) && reqs[c[5:0]];
            if (chg_pos >= 0 && got.size() == chg_pos && word_valid) data_rgb[12] = chg_val;
            if (rst_pos >= 0 && got.size() == rst_pos && word_valid && rst_n) begin
                #2 rst_n = 1'b0;
                #1 check("async_drop", {31'b0, word_valid}, 32'h0);
            end
            if (stall_pos >= 0 && got.size() == stall_pos && word_valid) begin
                if (stalls == 0) held = word_data;
                else if (word_data !== held) stall_bad++;
                word_ready = stalls >= 2;
                stalls++;
            end else begin
                word_ready = 1'b1;
            end
            if (busy) busy_cyc++;
            if (busy && !prev) begin
                starts++;
                if (starts == 2) start2 = c;
            end
            prev = busy;
            if (frame_done) begin
                done_cnt++;
                if (done_cnt == 1) done1 = c;
            end
            if (word_valid && word_ready) begin
                got.push_back(word_data);
                last_xfer = c;
            end
        end
        frame_req  = 1'b0;
        word_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) data_rgb[i] = {3'(i), 5'(31 - i), 8'(16 * i + 1), 8'(255 - i), 8'(7 * i)};

        repeat (3) @(negedge clk);
        check("rst_valid", {31'b0, word_valid}, 32'h0);
        check("rst_data", word_data, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, frame_done}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_spontaneous_start", {31'b0, busy}, 32'h0);

        run_frame(40, 64'h1, -1, -1, 32'h0, -1);
        check("f1_words", got.size(), 15);
        check_frame("f1", 0);
        check("f1_led0_hand", word_at(1), 32'hFF01_FF00);
        check("f1_led12_hand", word_at(13), 32'hF3C1_F354);
        check("f1_busy_cycles", busy_cyc, 15);
        check("f1_done_count", done_cnt, 1);
        check("f1_done_gap", done1 - last_xfer, 1);

        run_frame(40, 64'h1, 4, -1, 32'h0, -1);
        check("stall_words", got.size(), 15);
        check_frame("stall", 0);
        check("stall_stable", stall_bad, 0);
        check("stall_held", held, led(3));
        check("stall_busy_cycles", busy_cyc, 17);

        run_frame(45, 64'h121, -1, -1, 32'h0, -1);
        check("coal_words", got.size(), 30);
        check_frame("coal_a", 0);
        check_frame("coal_b", 15);
        check("coal_done_count", done_cnt, 2);
        check("coal_starts", starts, 2);
        check("coal_back_to_back", start2 - done1, 1);

        run_frame(30, 64'h1, -1, -1, 32'h0, 6);
        check("rst_mid_words", got.size(), 6);
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        run_frame(40, 64'h1, -1, -1, 32'h0, -1);
        check("after_rst_words", got.size(), 15);
        check_frame("after_rst", 0);

        orig = data_rgb[12];
        run_frame(40, 64'h1, -1, 3, 32'h0BAD_CAFE, -1);
        check("tear_words", got.size(), 15);
`ifdef LED_STRIP_SCHEDULER_SNAPSHOT_EN
        check("tear_led12", word_at(13), 32'hF3C1_F354);
`else
        check("tear_led12", word_at(13), 32'hEBAD_CAFE);
`endif
        data_rgb[12] = orig;

        sel = 1'b1;
        n_st = 0; n_dn = 0; prev_t = 0;
        @(negedge clk);
        rst_t = 1'b1;
        for (int c = 0; c < 3500; c++) begin
            @(negedge clk);
            frame_req = (c == 2985) || (c == 2990) || (c == 2993);
            if (busy && !prev_t) begin
                if (n_st < 4) st[n_st] = c;
                n_st++;
            end
            prev_t = busy;
            if (frame_done) begin
                if (n_dn < 4) dn[n_dn] = c;
                n_dn++;
            end
        end
        frame_req = 1'b0;
        check("tmr_starts", n_st, 4);
        check("tmr_dones", n_dn, 4);
        check("tmr_first_start", st[0], 1000);
        check("tmr_period", st[1] - st[0], 1000);
        check("tmr_req_start", st[2], 2987);
        check("tmr_coalesced_follow", st[3] - dn[2], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_strip_scheduler.md
LED_STRIP_SCHEDULER -- requirements
Module: led_strip_scheduler

Interface
REQ-001 The block SHALL have parameter clk_mhz, default 27: clock frequency in MHz.
REQ-002 The block SHALL have parameter n_leds, default 13: number of SK9822 LEDs on the strip.
REQ-003 The block SHALL have parameter refresh_hz, default 60: automatic frame refresh rate.
REQ-004 Port clk  input  1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port data_rgb  input  [0:n_leds-1][31:0]: per-LED frame {3'b111, bright[4:0], B, G, R}; element 0 is sent first.
REQ-007 Port frame_req  input  1: single-cycle request for an immediate frame.
REQ-008 Port word_ready  input  1: the serializer accepts word_data this cycle.
REQ-009 Port word_data  output  32: word offered to the serializer.
REQ-010 Port word_valid  output  1: word_data is valid.
REQ-011 Port busy  output  1: a frame is in progress.
REQ-012 Port frame_done  output  1: one-cycle pulse after the last end-frame word transfers.

Function
REQ-013 The FSM SHALL have the states IDLE, START, LEDS and END.
REQ-014 In IDLE with pending=1, the FSM SHALL move to START on the next edge and clear pending.
REQ-015 START SHALL offer 32'h0000_0000 once and move to LEDS on transfer.
REQ-016 LEDS SHALL offer words 0..n_leds-1 in order; the index increments on each transfer; after index n_leds-1 transfers, the FSM SHALL move to END.
REQ-017 Each LED word SHALL be forced to bits[31:29]=3'b111; the remaining bits SHALL pass through unchanged.
REQ-018 END SHALL offer n_end = 1 + n_leds/64 (integer division) words of 32'h0000_0000.
REQ-019 After the last END word transfers, the FSM SHALL return to IDLE and assert frame_done for one cycle.
REQ-020 A transfer SHALL occur on an edge where word_valid=1 and word_ready=1.
REQ-021 While word_valid=1 and word_ready=0, word_data SHALL hold stable.
REQ-022 word_valid SHALL never deassert before a transfer.
REQ-023 word_valid SHALL be 1 in START, LEDS and END, and 0 in IDLE.
REQ-024 Registered outputs SHALL have zero bubble cycles between consecutive words when word_ready is held at 1.
REQ-025 The refresh timer SHALL count 0..(clk_mhz*1_000_000/refresh_hz - 1) and wrap; on wrap it SHALL set pending.
REQ-026 The refresh timer SHALL free-run regardless of FSM state.
REQ-027 frame_req=1 SHALL set pending.
REQ-028 Requests arriving while busy SHALL coalesce into one pending flag, which is served right after frame_done.
REQ-029 When frame_req and a timer wrap occur in the same cycle, the block SHALL produce one pending frame.
REQ-030 busy SHALL equal (state != IDLE).
REQ-031 Widths of the LED index and the END counter SHALL be $clog2-sized with a minimum of 1 bit; index wrap beyond n_leds-1 SHALL never occur.

Reset
REQ-032 On rst_n=0, the block SHALL asynchronously enter IDLE with word_valid=0, word_data=0, busy=0, frame_done=0, pending=0, timer=0 and index=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no further words and no frame_done.
REQ-034 After release from reset, the first frame SHALL start only on frame_req or a timer wrap.

Configuration
REQ-035 With LED_STRIP_SCHEDULER_SNAPSHOT_EN defined, all of data_rgb SHALL be captured into a register array on the IDLE->START edge, and LED words SHALL come from that snapshot (no tearing).
REQ-036 Without LED_STRIP_SCHEDULER_SNAPSHOT_EN, LED word i SHALL be sampled live from data_rgb[i] when it is first offered, then held until transfer; no snapshot array is built.

Structure
REQ-037 The package led_strip_pkg SHALL hold the state enum, the START_WORD and END_WORD constants, the brightness-prefix constant 3'b111, and a function computing n_end.
REQ-038 The refresh timer SHALL be the sub-module led_strip_refresh_timer (clk, rst_n, tick).
REQ-039 The FSM and the word mux SHALL stay in the top module.

Verification
REQ-040 Test: n_leds=13, word_ready=1, frame_req pulse -> 15 words: 0x00000000, data_rgb[0..12] with [31:29]=111, 0x00000000; frame_done pulses 1 cycle after the last transfer; busy is high for 15 cycles.
REQ-041 Test: word_ready toggling 1,0,0,1 on LED word 3 -> word_data stays stable through the stall, and no word is duplicated or skipped.
REQ-042 Test: frame_req pulsed twice while busy, plus one timer wrap -> exactly one extra frame follows immediately after frame_done.
REQ-043 Test: clk_mhz=1, refresh_hz=1000, no frame_req -> frames start every 1000 cycles.
REQ-044 Test: rst_n low during LED word 5 -> word_valid drops asynchronously with no frame_done; the next frame_req produces a full, correct frame.
REQ-045 Test: SNAPSHOT_EN, data_rgb[12] changed during word 2 -> the old value is sent; without the macro, the new value is sent.
